// File: rtl/rd_fsm.sv
// rd_fsm: read-side controller of the double-buffered reorder FIFO.
// Drains full banks ping-pong (mem0 first) into a 2-entry valid/ready buffer.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem0_full, mem1_full  bank completely written (level)
//   mem0_lock, mem1_lock  bank owned by the reader
//   mem0_clr, mem1_clr    1-cycle pulse clearing the bank
//   rd_en, rd_sel,
//   rd_addr, rd_data      bank read port, data one cycle after rd_en
//   out_valid, out_ready,
//   out_data              downstream valid/ready port
module rd_fsm #(
   parameter int DEPTH = 16,
   parameter int DW    = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem0_full,
   input  logic          mem1_full,
   output logic          mem0_lock,
   output logic          mem1_lock,
   output logic          mem0_clr,
   output logic          mem1_clr,
   output logic          rd_en,
   output logic          rd_sel,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   localparam int S_IDLE = 0;
   localparam int S_RD0  = 1;
   localparam int S_RD1  = 2;
   localparam int S_CLR0 = 3;
   localparam int S_CLR1 = 4;

   localparam logic [4:0] ST_IDLE = 5'b00001;
   localparam logic [4:0] ST_RD0  = 5'b00010;
   localparam logic [4:0] ST_RD1  = 5'b00100;
   localparam logic [4:0] ST_CLR0 = 5'b01000;
   localparam logic [4:0] ST_CLR1 = 5'b10000;

   logic [4:0]    state_q, state_d;
   logic          next_bank_q, next_bank_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          inflight_q;
   logic [DW-1:0] buf_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    cnt_q, cnt_d;

   logic          push, pop, reading, credit, last_rd;
   logic [1:0]    occ;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = buf_q[rd_ptr_q];
   assign rd_addr   = rd_addr_q;

   assign push    = inflight_q;
   assign pop     = out_valid & out_ready;
   assign reading = state_q[S_RD0] | state_q[S_RD1];

   // Occupancy counts buffered words plus the read still in flight,
   // so a new read is only issued when its word is sure to fit.
   assign occ     = cnt_q + {1'b0, inflight_q};
   assign credit  = (occ < 2'd2) | (pop & (occ == 2'd2));
   assign last_rd = rd_en & (rd_addr_q == AW'(DEPTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         next_bank_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_bank_q <= next_bank_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      next_bank_d = next_bank_q;
      unique case (1'b1)
         state_q[S_IDLE]: begin
            if (!next_bank_q && mem0_full)
               state_d = ST_RD0;
            else if (next_bank_q && mem1_full)
               state_d = ST_RD1;
         end
         state_q[S_RD0]: begin
            if (last_rd)
               state_d = ST_CLR0;
         end
         state_q[S_RD1]: begin
            if (last_rd)
               state_d = ST_CLR1;
         end
         state_q[S_CLR0]: begin
            next_bank_d = 1'b1;
            state_d     = mem1_full ? ST_RD1 : ST_IDLE;
         end
         state_q[S_CLR1]: begin
            next_bank_d = 1'b0;
            state_d     = mem0_full ? ST_RD0 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      mem0_lock = state_q[S_RD0] | state_q[S_CLR0];
      mem1_lock = state_q[S_RD1] | state_q[S_CLR1];
      mem0_clr  = state_q[S_CLR0];
      mem1_clr  = state_q[S_CLR1];
      rd_sel    = state_q[S_RD1];
      rd_en     = reading & credit;
   end

   // Read address and buffer count next values
   always_comb begin
      rd_addr_d = rd_en ? rd_addr_q + AW'(1) : rd_addr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Read datapath and output buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
      end else begin
         rd_addr_q  <= rd_addr_d;
         inflight_q <= rd_en;
         cnt_q      <= cnt_d;
         if (push) begin
            buf_q[wr_ptr_q] <= rd_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule

// File: tb/tb_rd_fsm.sv
// tb_rd_fsm: directed bench for rd_fsm with a two-bank memory model.
// Bank0 holds addr+0x100, bank1 holds addr+0x200.
module tb_rd_fsm;

   localparam int DEPTH = 16;
   localparam int DW    = 32;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem0_full, mem1_full;
   logic          mem0_lock, mem1_lock;
   logic          mem0_clr, mem1_clr;
   logic          rd_en, rd_sel;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic          set0, set1;

   always #5 clk = ~clk;

   rd_fsm #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem0_full (mem0_full),
      .mem1_full (mem1_full),
      .mem0_lock (mem0_lock),
      .mem1_lock (mem1_lock),
      .mem0_clr  (mem0_clr),
      .mem1_clr  (mem1_clr),
      .rd_en     (rd_en),
      .rd_sel    (rd_sel),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Bank model: registered read, full set by the bench, cleared by clr
   always @(posedge clk) begin
      if (rd_en)
         rd_data <= (rd_sel ? 32'h200 : 32'h100) + 32'(rd_addr);
      if (!rst_n)       mem0_full <= 1'b0;
      else if (set0)    mem0_full <= 1'b1;
      else if (mem0_clr) mem0_full <= 1'b0;
      if (!rst_n)       mem1_full <= 1'b0;
      else if (set1)    mem1_full <= 1'b1;
      else if (mem1_clr) mem1_full <= 1'b0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor state
   logic [DW-1:0] got[$];
   int            pop_cyc[$];
   int            issued = 0, popped = 0;
   int            occ_bad = 0, stab_bad = 0, stab_n = 0;
   int            run0 = 0, run1 = 0, lock0_len = 0, lock1_len = 0;
   int            lock0_rise = 0, lock1_rise = 0;
   int            clr0_n = 0, clr1_n = 0, clr0_cyc = 0;
   logic          prev_stall = 1'b0, prev_l0 = 1'b0, prev_l1 = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         issued     = 0;
         popped     = 0;
         prev_stall = 1'b0;
         prev_l0    = 1'b0;
         prev_l1    = 1'b0;
         run0       = 0;
         run1       = 0;
      end else begin
         if (prev_stall) begin
            stab_n++;
            if (!out_valid || out_data !== prev_data) begin
               stab_bad++;
               $display("stalled word changed at cycle %0d", cyc);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            pop_cyc.push_back(cyc);
            popped++;
         end
         if (rd_en) issued++;
         if (issued - popped > 2) begin
            occ_bad++;
            $display("occupancy %0d at cycle %0d", issued - popped, cyc);
         end
         if (mem0_lock && !prev_l0) lock0_rise = cyc;
         if (mem1_lock && !prev_l1) lock1_rise = cyc;
         if (mem0_lock) run0++;
         else if (run0 != 0) begin lock0_len = run0; run0 = 0; end
         if (mem1_lock) run1++;
         else if (run1 != 0) begin lock1_len = run1; run1 = 0; end
         prev_l0 = mem0_lock;
         prev_l1 = mem1_lock;
      end
      if (mem0_clr) begin clr0_n++; clr0_cyc = cyc; end
      if (mem1_clr) clr1_n++;
   end

   int n_pass = 0, n_tot = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pulse0();
      set0 = 1'b1;
      tick();
      set0 = 1'b0;
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (got.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("word_timeout", 64'(got.size() >= n), 64'd1);
   endtask

   function automatic logic [DW-1:0] exp_word(input int i);
      return (i < DEPTH) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - DEPTH);
   endfunction

   typedef struct {
      logic       rst;
      logic       s0;
      logic       s1;
      logic       rdy;
      logic [6:0] ctl;   // lock0 lock1 clr0 clr1 rd_en rd_sel out_valid
      logic [3:0] addr;
      logic [31:0] dat;
   } vec_t;

   vec_t tv[9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b, c0, c1, n;
      logic act;

      tv[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 4'd0, 32'h0};
      tv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0000000, 4'd0, 32'h0};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 4'd0, 32'h0};
      tv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 4'd0, 32'h0};
      tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b0000000, 4'd0, 32'h0};
      tv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b1000100, 4'd0, 32'h0};
      tv[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b1000100, 4'd1, 32'h0};
      tv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b1000101, 4'd2, 32'h100};
      tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b1000101, 4'd3, 32'h101};

      rst_n     = 1'b0;
      set0      = 1'b0;
      set1      = 1'b0;
      out_ready = 1'b1;
      tick();

      // Reset, mem1-only idle, then bank0 start-up cycle by cycle
      b  = got.size();
      c0 = clr0_n;
      c1 = clr1_n;
      for (int i = 0; i < 9; i++) begin
         rst_n     = tv[i].rst;
         set0      = tv[i].s0;
         set1      = tv[i].s1;
         out_ready = tv[i].rdy;
         tick();
         chk($sformatf("vec%0d", i),
             {21'd0, mem0_lock, mem1_lock, mem0_clr, mem1_clr, rd_en,
              rd_sel, out_valid, rd_addr, out_data},
             {21'd0, tv[i].ctl, tv[i].addr, tv[i].dat});
      end

      // Both banks full: bank0 then bank1, straight from CLR0 into RD1
      wait_words(b + 2 * DEPTH, 200);
      repeat (4) tick();
      for (int i = 0; i < 2 * DEPTH; i++)
         chk($sformatf("both_word%0d", i), 64'(got[b + i]), 64'(exp_word(i)));
      chk("lock0_len", 64'(lock0_len), 64'(DEPTH + 1));
      chk("lock1_len", 64'(lock1_len), 64'(DEPTH + 1));
      chk("clr0_pulses", 64'(clr0_n - c0), 64'd1);
      chk("clr1_pulses", 64'(clr1_n - c1), 64'd1);
      chk("clr0_latency", 64'(clr0_cyc - lock0_rise), 64'(DEPTH));
      chk("lock1_after_clr0", 64'(lock1_rise), 64'(clr0_cyc + 1));
      chk("bank0_back_to_back", 64'(pop_cyc[b + DEPTH - 1] - pop_cyc[b]),
          64'(DEPTH - 1));

      // Backpressure from the start of a drain
      do_reset();
      out_ready = 1'b0;
      pulse0();
      b = got.size();
      n = 0;
      repeat (10) begin
         tick();
         if (rd_en) n++;
      end
      chk("stall_reads", 64'(n), 64'd2);
      chk("stall_head", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h100});
      out_ready = 1'b1;
      wait_words(b + DEPTH, 100);
      for (int i = 0; i < DEPTH; i++)
         chk($sformatf("stall_word%0d", i), 64'(got[b + i]), 64'(exp_word(i)));
      repeat (4) tick();

      // Random backpressure
      do_reset();
      pulse0();
      b = got.size();
      n = 0;
      while (got.size() < b + DEPTH && n < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      out_ready = 1'b1;
      chk("rand_count", 64'(got.size() - b), 64'(DEPTH));
      for (int i = 0; i < DEPTH && b + i < got.size(); i++)
         chk($sformatf("rand_word%0d", i), 64'(got[b + i]), 64'(exp_word(i)));
      repeat (4) tick();
      chk("stall_seen", 64'(stab_n > 0), 64'd1);
      chk("stall_stable", 64'(stab_bad), 64'd0);
      chk("occupancy", 64'(occ_bad), 64'd0);

      // Reset in the middle of bank0
      do_reset();
      c0 = clr0_n;
      pulse0();
      b = got.size();
      wait_words(b + 7, 50);
      rst_n = 1'b0;
      tick();
      chk("rst_outputs",
          {21'd0, mem0_lock, mem1_lock, mem0_clr, mem1_clr, rd_en,
           rd_sel, out_valid, rd_addr, out_data}, 64'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_no_clr", 64'(clr0_n - c0), 64'd0);

      // After reset next_bank is 0 again: mem1 alone is ignored
      set1 = 1'b1;
      tick();
      set1 = 1'b0;
      act  = 1'b0;
      repeat (6) begin
         tick();
         if (mem0_lock || mem1_lock || rd_en) act = 1'b1;
      end
      chk("nb0_ignore_mem1", 64'(act), 64'd0);
      pulse0();
      b = got.size();
      wait_words(b + 2 * DEPTH, 200);
      chk("post_rst_first", 64'(got[b]), 64'h100);
      chk("post_rst_bank1", 64'(got[b + DEPTH]), 64'h200);
      chk("post_rst_last", 64'(got[b + 2 * DEPTH - 1]), 64'h20F);
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
